seg7_capture: RTL and testbench



---
 rtl/seg7_capture.sv | 134 +++++++++++++
 tb/tb_seg7_capture.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// Reader side of the multiplexed 7-segment bus: waits for each digit pattern to
// settle, decodes it to hex, flags non-table patterns and reports complete frames.
module seg7_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            leds,
  input  logic [DIGITS-1:0]     an,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     err_mask,
  output logic                  digit_strobe,
  output logic [2:0]            digit_idx,
  output logic                  frame_valid
);

  localparam int SW = DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  // Returns {err, value}; anything outside the table decodes to 0 with err set.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h7E:   seg_decode = {1'b0, 4'h0};
      7'h30:   seg_decode = {1'b0, 4'h1};
      7'h6D:   seg_decode = {1'b0, 4'h2};
      7'h79:   seg_decode = {1'b0, 4'h3};
      7'h33:   seg_decode = {1'b0, 4'h4};
      7'h5B:   seg_decode = {1'b0, 4'h5};
      7'h5F:   seg_decode = {1'b0, 4'h6};
      7'h71:   seg_decode = {1'b0, 4'h7};
      7'h7F:   seg_decode = {1'b0, 4'h8};
      7'h73:   seg_decode = {1'b0, 4'h9};
      7'h77:   seg_decode = {1'b0, 4'hA};
      7'h1F:   seg_decode = {1'b0, 4'hB};
      7'h4E:   seg_decode = {1'b0, 4'hC};
      7'h3D:   seg_decode = {1'b0, 4'hD};
      7'h4F:   seg_decode = {1'b0, 4'hE};
      7'h47:   seg_decode = {1'b0, 4'hF};
      default: seg_decode = {1'b1, 4'h0};
    endcase
  endfunction

  function automatic logic is_onehot(input logic [DIGITS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < DIGITS; i++) begin
      n = n + int'(v[i]);
    end
    is_onehot = (n == 1);
  endfunction

  logic [SW-1:0]       r1_r, r2_r;
  logic [CW-1:0]       cnt_r;
  logic                done_r;
  logic [DIGITS-1:0]   seen_r;

  logic [DIGITS-1:0]   an_s;
  logic                stable_s;
  logic                capture_s;
  logic [4:0]          dec_s;
  logic [2:0]          idx_s;
  logic [DIGITS-1:0]   seen_nxt_s;
  logic                frame_s;
  logic [4*DIGITS-1:0] digits_nxt_s;
  logic [DIGITS-1:0]   err_nxt_s;

  // Capture decision and next-value computation for the registered outputs.
  always_comb begin
    an_s         = r1_r[SW-1:7];
    stable_s     = (r1_r == r2_r);
    dec_s        = seg_decode(r1_r[6:0]);
    capture_s    = stable_s && (cnt_r == CNT_MAX) && !done_r && is_onehot(an_s);
    idx_s        = 3'd0;
    digits_nxt_s = digits;
    err_nxt_s    = err_mask;
    // an_s is one-hot whenever capture_s is set, so it doubles as the write select.
    for (int i = 0; i < DIGITS; i++) begin
      if (an_s[i]) begin
        idx_s                 = 3'(i);
        digits_nxt_s[4*i +: 4] = dec_s[3:0];
        err_nxt_s[i]          = dec_s[4];
      end else begin
        idx_s = idx_s;
      end
    end
    seen_nxt_s = seen_r | an_s;
    frame_s    = (seen_nxt_s == {DIGITS{1'b1}});
  end

  // Sampling pipeline, settle counter and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_r         <= {SW{1'b0}};
      r2_r         <= {SW{1'b0}};
      cnt_r        <= {CW{1'b0}};
      done_r       <= 1'b0;
      seen_r       <= {DIGITS{1'b0}};
      digits       <= {(4*DIGITS){1'b0}};
      err_mask     <= {DIGITS{1'b0}};
      digit_strobe <= 1'b0;
      digit_idx    <= 3'd0;
      frame_valid  <= 1'b0;
    end else begin
      r1_r         <= {an, leds};
      r2_r         <= r1_r;
      digit_strobe <= 1'b0;
      frame_valid  <= 1'b0;
      if (!stable_s) begin
        cnt_r  <= {CW{1'b0}};
        done_r <= 1'b0;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (capture_s) begin
        digit_strobe <= 1'b1;
        digit_idx    <= idx_s;
        digits       <= digits_nxt_s;
        err_mask     <= err_nxt_s;
        done_r       <= 1'b1;
        if (frame_s) begin
          frame_valid <= 1'b1;
          seen_r      <= {DIGITS{1'b0}};
        end else begin
          seen_r <= seen_nxt_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Self-checking bench for seg7_capture: run-length behavioural model compared every
// cycle, plus directed scenarios with hand-computed latencies and values.
module tb_seg7_capture;
  localparam int DIGITS = 4;
  localparam int S      = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [6:0]        leds = 7'h7F;
  logic [DIGITS-1:0] an = 4'b0001;
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0] err_mask;
  logic              digit_strobe;
  logic [2:0]        digit_idx;
  logic              frame_valid;

  seg7_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .leds(leds), .an(an), .digits(digits),
    .err_mask(err_mask), .digit_strobe(digit_strobe), .digit_idx(digit_idx),
    .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: a pattern is captured once it has been sampled S+1 times in a row.
  logic [6:0]        seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h71,
                                      7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [3:0]        m_dig [DIGITS];
  logic [DIGITS-1:0] m_err, m_seen;
  logic              m_strobe, m_frame;
  logic [2:0]        m_idx;
  logic [10:0]       last;
  int                run;
  bit                model_on = 1'b0;
  int                m_i;
  logic [3:0]        m_v;
  logic              m_bad;

  always @(posedge clk) begin
    if (rst) begin
      for (int d = 0; d < DIGITS; d++) m_dig[d] = 4'h0;
      m_err = '0; m_seen = '0; m_strobe = 1'b0; m_frame = 1'b0; m_idx = 3'd0;
      last = 11'h0; run = 1; model_on = 1'b1;
    end else begin
      m_strobe = 1'b0;
      m_frame  = 1'b0;
      if (run == S + 1 && $countones(last[10:7]) == 1) begin
        m_i = 0;
        for (int d = 0; d < DIGITS; d++) if (last[7+d]) m_i = d;
        m_v = 4'h0; m_bad = 1'b1;
        for (int k = 0; k < 16; k++) if (seg_tab[k] == last[6:0]) begin m_v = k[3:0]; m_bad = 1'b0; end
        m_dig[m_i] = m_v;
        m_err[m_i] = m_bad;
        m_idx = m_i[2:0];
        m_strobe = 1'b1;
        m_seen[m_i] = 1'b1;
        if (m_seen == 4'b1111) begin m_frame = 1'b1; m_seen = '0; end
      end
      if ({an, leds} == last) begin
        if (run < 1000) run++;
      end else begin
        last = {an, leds};
        run = 1;
      end
    end
  end

  // Every-cycle comparison against the model, plus event counters.
  int n_strobe = 0, n_frame = 0, n_frame_idx3 = 0;
  always @(negedge clk) begin
    if (model_on) begin
      check("strobe", digit_strobe, m_strobe);
      check("frame", frame_valid, m_frame);
      check("idx", digit_idx, m_idx);
      check("err", err_mask, m_err);
      for (int d = 0; d < DIGITS; d++) check("digit", digits[4*d +: 4], m_dig[d]);
      n_strobe += int'(digit_strobe);
      n_frame  += int'(frame_valid);
      if (frame_valid && digit_strobe && digit_idx == 3'd3) n_frame_idx3++;
    end
  end

  // Drive a pattern and hold it for maxc edges; lat = edge number (1 = first) of the first strobe.
  task automatic drive_wait(input logic [3:0] a, input logic [6:0] l, input int maxc, output int lat);
    @(negedge clk);
    an = a; leds = l; lat = 0;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk); #1;
      if (digit_strobe && lat == 0) lat = i;
    end
  endtask

  int lat, s0, f0, q0;
  logic [6:0] frame_pat [4] = '{7'h79, 7'h33, 7'h5B, 7'h47};

  initial begin
    repeat (3) @(negedge clk);
    check("reset_strobes", n_strobe, 0);
    check("reset_digits", digits, 16'h0000);
    rst = 1'b0;

    s0 = n_strobe;
    drive_wait(4'b0001, 7'h6D, 10, lat);
    check("single_lat", lat, 6);
    check("single_count", n_strobe - s0, 1);
    check("single_val", digits[3:0], 4'h2);
    check("single_idx", digit_idx, 3'd0);
    check("single_err", err_mask, 4'b0000);

    s0 = n_strobe; f0 = n_frame; q0 = n_frame_idx3;
    for (int d = 0; d < 4; d++) begin
      drive_wait(4'(1 << d), frame_pat[d], 8, lat);
      check("frame_lat", lat, 6);
    end
    check("frame_strobes", n_strobe - s0, 4);
    check("frame_pulses", n_frame - f0, 1);
    check("frame_with_idx3", n_frame_idx3 - q0, 1);
    check("frame_digits", digits, 16'hF543);

    s0 = n_strobe;
    drive_wait(4'b0010, 7'h30, 3, lat);
    check("glitch_pre", lat, 0);
    drive_wait(4'b0010, 7'h00, 1, lat);
    check("glitch_blip", lat, 0);
    drive_wait(4'b0010, 7'h30, 10, lat);
    check("glitch_lat", lat, 6);
    check("glitch_count", n_strobe - s0, 1);
    check("glitch_val", digits[7:4], 4'h1);

    drive_wait(4'b0100, 7'h55, 8, lat);
    check("invalid_lat", lat, 6);
    check("invalid_err", err_mask, 4'b0100);
    check("invalid_val", digits[11:8], 4'h0);
    drive_wait(4'b0100, 7'h4E, 8, lat);
    check("recap_lat", lat, 6);
    check("recap_err", err_mask, 4'b0000);
    check("recap_val", digits[11:8], 4'hC);

    s0 = n_strobe;
    drive_wait(4'b0011, 7'h30, 10, lat);
    check("ghost_lat", lat, 0);
    check("ghost_count", n_strobe - s0, 0);

    f0 = n_frame;
    drive_wait(4'b1000, 7'h3D, 4, lat);
    check("rstmid_pre", lat, 0);
    @(negedge clk); rst = 1'b1;
    s0 = n_strobe;
    @(negedge clk); @(negedge clk);
    check("rstmid_during", n_strobe - s0, 0);
    rst = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (digit_strobe && lat == 0) lat = i;
    end
    check("rstmid_lat", lat, 6);
    check("rstmid_idx", digit_idx, 3'd3);
    check("rstmid_digits", digits, 16'hD000);
    check("rstmid_frame", n_frame - f0, 0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
